// File: rtl/mul_ha_pkg.sv
// Shared types and helpers for the time-shared half-adder row-pair multiplier.
// Holds the FSM state type, the default sizes, and the row-pair weighting function.
package mul_ha_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_PAIRS  = DEF_WIDTH / 2;
  localparam int DEF_PROD_W = 2 * DEF_WIDTH;

  // Widest operand the weighting helper supports; callers zero-extend into it.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // rowval = sum t[i]<<i + sum b[i]<<(i+2)
  function automatic logic [MAX_W+1:0] rowpair_weight(input logic [MAX_W:0]   t,
                                                      input logic [MAX_W-2:0] b);
    logic [MAX_W+1:0] sum;
    sum = '0;
    for (int i = 0; i <= MAX_W; i++) begin
      sum = sum + ((MAX_W+2)'(t[i]) << i);
    end
    for (int i = 0; i <= MAX_W - 2; i++) begin
      sum = sum + ((MAX_W+2)'(b[i]) << (i + 2));
    end
    return sum;
  endfunction

endpackage

// File: rtl/unsigned_mul_8x8_ha_seq_ctrl_ha_rowpair.sv
// Combinational half-adder row-pair unit: reduces y*x[2k] and y*x[2k+1] into sum bits t and carry bits b.
// APPROX_LSB_EN: when defined, row pair 0 drops its column-1 terms and replaces the column-3 half adder with an OR.
import mul_ha_pkg::*;

module ha_rowpair #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] y,
  input  logic             xa,
  input  logic             xb,
  input  logic             is_pair0,
  output logic [WIDTH:0]   t,
  output logic [WIDTH-2:0] b
);

  always_comb begin
    t = '0;
    b = '0;
    t[0] = y[0] & xa;
    for (int i = 1; i < WIDTH; i++) begin
      t[i]   = (y[i] & xa) ^ (y[i-1] & xb);
      b[i-1] = (y[i] & xa) & (y[i-1] & xb);
    end
    // Top partial product of the xb row has nothing to pair with; it sits alone in column WIDTH.
    t[WIDTH] = y[WIDTH-1] & xb;
`ifdef APPROX_LSB_EN
    if (is_pair0) begin
      t[1] = 1'b0;
      b[0] = 1'b0;
      t[3] = (y[3] & xa) | (y[2] & xb);
      b[2] = 1'b0;
    end
`endif
  end

`ifndef APPROX_LSB_EN
  logic pair0_unused;
  assign pair0_unused = is_pair0;
`endif

endmodule

// File: rtl/unsigned_mul_8x8_ha_seq_ctrl.sv
// Sequential unsigned multiplier: one ha_rowpair unit is reused over WIDTH/2 cycles with ready/valid on both sides.
// APPROX_LSB_EN (optional macro) approximates row pair 0 inside ha_rowpair.
import mul_ha_pkg::*;

module unsigned_mul_8x8_ha_seq_ctrl #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic              busy
);

  localparam int PAIRS  = WIDTH / 2;
  localparam int PROD_W = 2 * WIDTH;
  localparam int IDX_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  state_e              state, next_state;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    x_q, y_q;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   addend;
  logic                xa, xb, last_pair;
  logic [WIDTH:0]      t;
  logic [WIDTH-2:0]    b;
  logic [MAX_W:0]      t_ext;
  logic [MAX_W-2:0]    b_ext;
  logic [MAX_W+1:0]    weight_all;
  logic [WIDTH+1:0]    rowval;
  logic                weight_hi_unused;

  assign xa        = x_q[{idx, 1'b0}];
  assign xb        = x_q[{idx, 1'b1}];
  assign last_pair = (idx == IDX_W'(PAIRS - 1));

  ha_rowpair #(.WIDTH(WIDTH)) u_rowpair (
    .y        (y_q),
    .xa       (xa),
    .xb       (xb),
    .is_pair0 (idx == '0),
    .t        (t),
    .b        (b)
  );

  always_comb begin
    t_ext = '0;
    b_ext = '0;
    t_ext[WIDTH:0]   = t;
    b_ext[WIDTH-2:0] = b;
    weight_all = rowpair_weight(t_ext, b_ext);
    rowval     = weight_all[WIDTH+1:0];
    addend     = {{(PROD_W-WIDTH-2){1'b0}}, rowval} << {idx, 1'b0};
  end

  assign weight_hi_unused = |weight_all[MAX_W+1:WIDTH+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // abort outranks the output handshake; in_valid is only looked at in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid)                next_state = RUN;
      RUN:  if (abort)                   next_state = IDLE;
            else if (last_pair)          next_state = DONE;
      DONE: if (abort || out_ready)      next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      acc     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_q <= x;
          y_q <= y;
          acc <= '0;
          idx <= '0;
        end
        RUN: if (abort) begin
          acc <= '0;
          idx <= '0;
        end else if (last_pair) begin
          acc     <= acc + addend;
          product <= acc + addend;
          idx     <= '0;
        end else begin
          acc <= acc + addend;
          idx <= idx + 1'b1;
        end
        DONE: if (abort) acc <= '0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_seq_ctrl.sv
// Self-checking bench for unsigned_mul_8x8_ha_seq_ctrl: directed table, handshake/abort/reset corners, random scoreboard.
module tb_unsigned_mul_8x8_ha_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [7:0]  x, y;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [15:0] exp;
  } vec_t;

  unsigned_mul_8x8_ha_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact product; the approximate build loses the column-1 terms of pair 0
  // and, where both column-3 terms of pair 0 are set, the carry an OR cannot produce.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] c);
    int r;
    r = int'(a) * int'(c);
`ifdef APPROX_LSB_EN
    r = r - 2 * (int'(c[1] & a[0]) + int'(c[0] & a[1]));
    r = r - 8 * int'(c[3] & a[0] & c[2] & a[1]);
`endif
    return 16'(r);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one operand pair, wait for out_valid; lat counts edges after the accept edge.
  task automatic applyStimulus(input logic [7:0] ax, input logic [7:0] ay,
                               output logic [15:0] got, output int lat);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    x = ax;
    y = ay;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = product;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] got;
    logic [15:0] q[$];
    logic [15:0] expv;
    int          lat;
    int          got_cnt;
    bit          saw_valid;

    vecs[0] = '{8'd255, 8'd255, ref_mul(8'd255, 8'd255)};
    vecs[1] = '{8'd3,   8'd12,  ref_mul(8'd3,   8'd12)};
    vecs[2] = '{8'd1,   8'd2,   ref_mul(8'd1,   8'd2)};
    vecs[3] = '{8'd0,   8'd77,  16'd0};
    vecs[4] = '{8'd200, 8'd0,   16'd0};
    vecs[5] = '{8'd170, 8'd85,  ref_mul(8'd170, 8'd85)};

    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    #12;
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    checkOutput("reset_product",   32'(product),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].vx, vecs[i].vy, got, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d_product", i), 32'(got), 32'(vecs[i].exp));
      consume();
    end
    checkOutput("spec_3x12", 32'(ref_mul(8'd3, 8'd12)),
`ifdef APPROX_LSB_EN
                32'd28);
`else
                32'd36);
`endif

    // Back-pressure: DONE held for five cycles.
    applyStimulus(8'd99, 8'd201, got, lat);
    expv = ref_mul(8'd99, 8'd201);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_product",   32'(product),   32'(expv));
      checkOutput("hold_in_ready",  32'(in_ready),  32'd0);
    end
    consume();
    checkOutput("release_in_ready",  32'(in_ready),  32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_product_kept", 32'(product),   32'(expv));

    // Abort during the second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1; x = 8'd200; y = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_busy",     32'(busy),     32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_out_valid", 32'(saw_valid), 32'd0);
    applyStimulus(8'd17, 8'd9, got, lat);
    checkOutput("after_abort_product", 32'(got), 32'd153);
    consume();

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    in_valid = 1'b1; x = 8'd123; y = 8'd45;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("async_rst_busy",      32'(busy),      32'd0);
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_product",   32'(product),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Random back-to-back traffic against a scoreboard queue.
    got_cnt = 0;
    for (int c = 0; c < 820; c++) begin
      @(negedge clk);
      if (c < 800) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        x         = 8'($urandom);
        y         = 8'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("rand_spurious_output", 32'd1, 32'd0);
        end else begin
          expv = q.pop_front();
          checkOutput("rand_product", 32'(product), 32'(expv));
          got_cnt++;
        end
      end
      if (in_valid && in_ready) q.push_back(ref_mul(x, y));
    end
    checkOutput("rand_queue_drained", 32'(q.size()), 32'd0);
    checkOutput("rand_enough_results", 32'(got_cnt > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
